tw_rom1_loader: RTL
===================

Name: tw_rom1_loader

Overview:
- Upstream feeder for the stage-0 twiddle buffer of the 1024-point/128-bit twiddle ROM.
- Accepts ENTRY_NUM 128-bit twiddle words from the twiddle-update path over a valid/ready handshake and buffers them locally.
- Replays the buffered words to the ROM's 64-bit horizontal write port as one contiguous burst: all high halves first, then all low halves, driving the ROM's 2-bit write code.
- Guarantees the burst timing the ROM's free-running write index needs: no bubbles inside a burst, and a zero-code cycle after it.

Parameters:
- P_WIDTH, 128, twiddle word width.
- horizontal_DW, 64, ROM write-port width; must equal P_WIDTH/2.
- ENTRY_NUM, 4, words per burst; must equal the ROM's stage-0 entry count.
- IDX_WIDTH, 2, clog2(ENTRY_NUM).

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  P_WIDTH  twiddle word {hi64, lo64}.
- hold  in  1  ROM is being read (its CEN low); burst must not start while 1.
- horizontal_data_out  out  horizontal_DW  half-word to the ROM.
- ROM1_w  out  2  write code: 0 = none, 1 = high half, 2 = low half; 3 is never driven.
- busy  out  1  high in WAIT, HI, LO, GAP.
- done  out  1  one-cycle pulse in GAP.

Behaviour:
- FSM states: FILL, WAIT, HI, LO, GAP. Counters: fill_cnt and idx, each IDX_WIDTH+1 bits wide.
- Reset (rst=1 at an edge): state=FILL, fill_cnt=0, idx=0, in_ready=1, ROM1_w=0, horizontal_data_out=0, busy=0, done=0. The buffer contents are don't-care.
- Reset mid-burst: ROM1_w returns to 0 at that edge. The partial ROM update is accepted, and the ROM's write index self-clears because the code is 0.
- All outputs are registered and Moore-style: their values in a cycle reflect the state held during that cycle.

FILL:
- in_ready=1.
- On in_valid & in_ready: buf[fill_cnt] <= in_data and fill_cnt++.
- On the ENTRY_NUM-th accept: go to WAIT, clear fill_cnt, and drop in_ready in the next cycle.
- Words are stored in acceptance order. Entry 0 is the first accepted word.

WAIT:
- in_ready=0.
- If hold=0: go to HI with idx=0. Otherwise stay in WAIT.
- hold is sampled only in WAIT. Once HI is entered, hold is ignored until GAP.

HI:
- Runs exactly ENTRY_NUM consecutive cycles.
- ROM1_w=1 and horizontal_data_out=buf[idx][P_WIDTH-1:horizontal_DW] for idx=0..ENTRY_NUM-1.
- After the last index: idx wraps to 0 and the FSM goes directly to LO with no gap cycle. This matches the ROM index wrapping from ENTRY_NUM-1 to 0.

LO:
- Runs exactly ENTRY_NUM consecutive cycles.
- ROM1_w=2 and horizontal_data_out=buf[idx][horizontal_DW-1:0].
- After the last index: go to GAP.

GAP:
- Lasts one cycle: ROM1_w=0, horizontal_data_out=0, done=1.
- Next state is FILL.

Timing:
- Minimum period between bursts: ENTRY_NUM accepts, plus 1 WAIT, plus 2*ENTRY_NUM burst cycles, plus 1 GAP.
- A burst occupies exactly 2*ENTRY_NUM contiguous non-zero ROM1_w cycles.

Boundary conditions:
- in_valid held high across the FILL→WAIT boundary: exactly ENTRY_NUM words are accepted and the next word waits.
- in_data is ignored whenever in_ready=0.
- hold toggling during HI or LO has no effect on the burst.

Decomposition:
- Shared package tw_pkg holds:
  - ROM write-code constants: TW_W_NONE=0, TW_W_HI=1, TW_W_LO=2.
  - The state enum.
  - P_WIDTH, horizontal_DW and ENTRY_NUM defaults, shared with the ROM.
- Single module; no sub-module is needed. The buffer is a small register array (ENTRY_NUM x P_WIDTH) inside this block.

Test Plan:
- Reset then back-to-back load: rst for 2 cycles. Send words W0..W3 with in_valid=1 each cycle, hold=0.
  - Expect in_ready=0 from the cycle after W3.
  - Expect one WAIT cycle, then ROM1_w=1 for 4 cycles carrying W0..W3[127:64], then ROM1_w=2 for 4 cycles carrying W0..W3[63:0].
  - Then GAP with done=1 and ROM1_w=0.
  - Check against the known values: W1 = 128'hfffdffff00000003_5b11501d07d1bfa5 gives hi 64'hfffdffff00000003 and lo 64'h5b11501d07d1bfa5.
- Hold stall: fill 4 words with hold=1 for 10 cycles.
  - Expect busy=1 and ROM1_w=0 throughout.
  - Expect HI to start exactly 1 cycle after hold falls.
  - Raising hold during LO does not interrupt the burst.
- Sparse upstream: in_valid asserted every 3rd cycle.
  - Expect the 4 words stored in acceptance order and in_ready=1 throughout FILL.
  - Burst content matches the order-sensitive expected words.
- Mid-burst reset: rst on the 3rd HI cycle.
  - Expect ROM1_w=0 in the next cycle and state FILL with in_ready=1.
  - A fresh 4-word load then bursts correctly.
- End-to-end with ROM model: load 4 random words into the ROM model, then read with CEN low and stage_counter=0.
  - Expect Q to sequence through the 4 loaded words.
  - Check the ROM write index is 0 after GAP.

Source files
------------

// File: rtl/tw_pkg.sv
// rtl/tw_pkg.sv - shared twiddle ROM constants, write codes and loader state type
//
// Holds the defaults shared between the stage-0 twiddle ROM and its loader:
// word widths, the stage-0 entry count, the ROM 2-bit write codes and the
// loader FSM state enumeration.
package tw_pkg;

    localparam int TW_P_WIDTH   = 128;
    localparam int TW_HDW       = 64;
    localparam int TW_ENTRY_NUM = 4;

    localparam logic [1:0] TW_W_NONE = 2'd0;
    localparam logic [1:0] TW_W_HI   = 2'd1;
    localparam logic [1:0] TW_W_LO   = 2'd2;

    typedef enum logic [2:0] {
        ST_FILL = 3'd0,
        ST_WAIT = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_GAP  = 3'd4
    } tw_state_e;

endpackage

// File: rtl/tw_rom1_loader.sv
// rtl/tw_rom1_loader.sv - buffers ENTRY_NUM twiddle words and bursts them into the stage-0 ROM
//
// Ports:
//   CLK                 clock, all state changes on the rising edge
//   rst                 synchronous active-high reset
//   in_valid/in_ready   upstream word handshake
//   in_data             twiddle word {hi, lo}
//   hold                ROM is being read; a burst may not start while high
//   horizontal_data_out half-word driven to the ROM write port
//   ROM1_w              ROM write code (0 none, 1 high half, 2 low half)
//   busy                high in WAIT, HI, LO and GAP
//   done                one-cycle pulse in GAP
module tw_rom1_loader
    import tw_pkg::*;
#(
    parameter int P_WIDTH       = TW_P_WIDTH,
    parameter int horizontal_DW = TW_HDW,
    parameter int ENTRY_NUM     = TW_ENTRY_NUM,
    parameter int IDX_WIDTH     = $clog2(ENTRY_NUM)
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [P_WIDTH-1:0]       in_data,
    input  logic                     hold,
    output logic [horizontal_DW-1:0] horizontal_data_out,
    output logic [1:0]               ROM1_w,
    output logic                     busy,
    output logic                     done
);

    localparam logic [IDX_WIDTH:0] LAST_IDX = (IDX_WIDTH+1)'(ENTRY_NUM - 1);

    tw_state_e          state;
    tw_state_e          state_next;
    logic [IDX_WIDTH:0] fill_cnt;
    logic [IDX_WIDTH:0] fill_next;
    logic [IDX_WIDTH:0] idx;
    logic [IDX_WIDTH:0] idx_next;

    logic [P_WIDTH-1:0] buf_mem [ENTRY_NUM];
    logic [P_WIDTH-1:0] rd_word;

    logic                     accept;
    logic                     ready_next;
    logic                     busy_next;
    logic                     done_next;
    logic [1:0]               w_next;
    logic [horizontal_DW-1:0] data_next;

    // in_ready is a registered copy of "state is FILL", so it is a safe
    // qualifier for the handshake in the same cycle.
    assign accept = in_valid & in_ready;

    always_comb begin
        state_next = state;
        fill_next  = fill_cnt;
        idx_next   = idx;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (fill_cnt == LAST_IDX) begin
                        fill_next  = '0;
                        state_next = ST_WAIT;
                    end else begin
                        fill_next = fill_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!hold) begin
                    idx_next   = '0;
                    state_next = ST_HI;
                end
            end
            ST_HI: begin
                // Wrap straight into LO: the ROM write index wraps at the
                // same moment, so no bubble is allowed here.
                if (idx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = ST_LO;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ST_LO: begin
                if (idx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ST_GAP: begin
                state_next = ST_FILL;
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state and index and registered,
    // so each output cycle reflects the state held in that same cycle.
    assign rd_word = buf_mem[idx_next[IDX_WIDTH-1:0]];

    always_comb begin
        w_next     = TW_W_NONE;
        data_next  = '0;
        ready_next = (state_next == ST_FILL);
        busy_next  = (state_next != ST_FILL);
        done_next  = (state_next == ST_GAP);
        case (state_next)
            ST_HI: begin
                w_next    = TW_W_HI;
                data_next = rd_word[P_WIDTH-1:horizontal_DW];
            end
            ST_LO: begin
                w_next    = TW_W_LO;
                data_next = rd_word[horizontal_DW-1:0];
            end
            default: begin
                w_next    = TW_W_NONE;
                data_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state               <= ST_FILL;
            fill_cnt            <= '0;
            idx                 <= '0;
            in_ready            <= 1'b1;
            ROM1_w              <= TW_W_NONE;
            horizontal_data_out <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            state               <= state_next;
            fill_cnt            <= fill_next;
            idx                 <= idx_next;
            in_ready            <= ready_next;
            ROM1_w              <= w_next;
            horizontal_data_out <= data_next;
            busy                <= busy_next;
            done                <= done_next;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge CLK) begin
        if (accept) begin
            buf_mem[fill_cnt[IDX_WIDTH-1:0]] <= in_data;
        end
    end

endmodule
